// File: rtl/ps2_pkg.sv
// Shared types for the PS/2 host transmitter and its line filter.
// Optional timeouts are enabled with PS2_TX_TIMEOUT_EN.
package ps2_pkg;

  typedef enum logic [2:0] {
    IDLE,
    INHIBIT,
    START,
    WAIT_CLK,
    SHIFT,
    ACK,
    WAIT_IDLE
  } ps2_tx_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'd0,
    ERR_START_TO = 2'd1,
    ERR_XFER_TO  = 2'd2,
    ERR_NO_ACK   = 2'd3
  } ps2_tx_err_t;

  localparam int START_CYCLES = 50;

  function automatic int us_to_cycles(
    input int freq_hz,
    input int us
  );
    return (freq_hz / 1_000_000) * us;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Command handshake between a requester and the PS/2 host transmitter.
// Optional timeouts are enabled with PS2_TX_TIMEOUT_EN.
interface ps2_host_tx_if;
  logic [7:0] data_i;
  logic       data_valid_i;
  logic       ready_o;
  logic       done_o;
  logic       error_o;
  logic [1:0] err_code_o;

  modport master (
    output data_i,
    output data_valid_i,
    input  ready_o,
    input  done_o,
    input  error_o,
    input  err_code_o
  );

  modport slave (
    input  data_i,
    input  data_valid_i,
    output ready_o,
    output done_o,
    output error_o,
    output err_code_o
  );
endinterface

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus glitch filter for one PS/2 pad line.
// Shared with the receive controller; PS2_TX_TIMEOUT_EN has no effect here.
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic filt_o,
  output logic fall_o
);

  localparam int CW = $clog2(FILTER_LEN + 1);
  localparam logic [CW-1:0] LAST = CW'(FILTER_LEN - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_filt;
  logic          r_fall;
  logic [CW-1:0] r_cnt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_s1   <= 1'b1;
      r_s2   <= 1'b1;
      r_filt <= 1'b1;
      r_fall <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= line_i;
      r_s2   <= r_s1;
      r_fall <= 1'b0;
      if (r_s2 == r_filt) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_filt <= r_s2;
        r_fall <= r_filt;
        r_cnt  <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end
  end

  assign filt_o = r_filt;
  assign fall_o = r_fall;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving open-drain enables.
// Define PS2_TX_TIMEOUT_EN to add start and transfer timeouts.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int CLK_FREQ_HZ      = 50_000_000,
  parameter int INHIBIT_US       = 120,
  parameter int START_TIMEOUT_US = 15000,
  parameter int XFER_TIMEOUT_US  = 2000,
  parameter int FILTER_LEN       = 8
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ps2_host_tx_if.slave bus,
  input  logic         ps2_clk_i,
  input  logic         ps2_dat_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_dat_oe_o,
  output logic         rx_inhibit_o
);

  localparam int INH_CYC = us_to_cycles(CLK_FREQ_HZ, INHIBIT_US);
  localparam int STO_CYC = us_to_cycles(CLK_FREQ_HZ, START_TIMEOUT_US);
  localparam int XTO_CYC = us_to_cycles(CLK_FREQ_HZ, XFER_TIMEOUT_US);
  localparam logic [31:0] INH_LAST = 32'(INH_CYC - 1);
  localparam logic [31:0] STA_LAST = 32'(START_CYCLES - 1);

  logic w_clk_f;
  logic w_clk_fall;
  logic w_dat_f;
  logic w_unused_dat_fall;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_flt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (ps2_clk_i),
    .filt_o (w_clk_f),
    .fall_o (w_clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_flt (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .line_i (ps2_dat_i),
    .filt_o (w_dat_f),
    .fall_o (w_unused_dat_fall)
  );

  ps2_tx_state_t r_state, w_state_nxt;
  ps2_tx_err_t   r_code, w_code_nxt;
  logic [31:0]   r_cnt, w_cnt_nxt;
  logic [9:0]    r_frame, w_frame_nxt;
  logic [3:0]    r_bit, w_bit_nxt;
  logic          r_clk_oe, w_clk_oe_nxt;
  logic          r_dat_oe, w_dat_oe_nxt;
  logic          r_done, w_done_nxt;
  logic          r_err, w_err_nxt;

`ifdef PS2_TX_TIMEOUT_EN
  localparam logic [31:0] STO_LAST = 32'(STO_CYC - 1);
  localparam logic [31:0] XTO_LAST = 32'(XTO_CYC - 1);
  logic [31:0] r_to, w_to_nxt;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_to <= '0;
    else        r_to <= w_to_nxt;
  end
`else
  logic [31:0] w_unused_to;
  assign w_unused_to = STO_CYC ^ XTO_CYC;
`endif

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state  <= IDLE;
      r_code   <= ERR_NONE;
      r_cnt    <= '0;
      r_frame  <= '0;
      r_bit    <= '0;
      r_clk_oe <= 1'b0;
      r_dat_oe <= 1'b0;
      r_done   <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_code   <= w_code_nxt;
      r_cnt    <= w_cnt_nxt;
      r_frame  <= w_frame_nxt;
      r_bit    <= w_bit_nxt;
      r_clk_oe <= w_clk_oe_nxt;
      r_dat_oe <= w_dat_oe_nxt;
      r_done   <= w_done_nxt;
      r_err    <= w_err_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_code_nxt   = r_code;
    w_cnt_nxt    = r_cnt;
    w_frame_nxt  = r_frame;
    w_bit_nxt    = r_bit;
    w_clk_oe_nxt = r_clk_oe;
    w_dat_oe_nxt = r_dat_oe;
    w_done_nxt   = 1'b0;
    w_err_nxt    = 1'b0;
`ifdef PS2_TX_TIMEOUT_EN
    w_to_nxt     = r_to;
`endif
    unique case (r_state)
      IDLE: begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        if (bus.data_valid_i) begin
          // frame = {stop, odd parity, data}, shifted out LSB first
          w_frame_nxt  = {1'b1, ~^bus.data_i, bus.data_i};
          w_bit_nxt    = '0;
          w_cnt_nxt    = '0;
          w_code_nxt   = ERR_NONE;
          w_clk_oe_nxt = 1'b1;
          w_state_nxt  = INHIBIT;
        end
      end
      INHIBIT: begin
        if (r_cnt == INH_LAST) begin
          w_cnt_nxt    = '0;
          w_dat_oe_nxt = 1'b1;
          w_state_nxt  = START;
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      START: begin
        if (r_cnt == STA_LAST) begin
          w_cnt_nxt    = '0;
          w_clk_oe_nxt = 1'b0;
          w_state_nxt  = WAIT_CLK;
`ifdef PS2_TX_TIMEOUT_EN
          w_to_nxt     = '0;
`endif
        end else begin
          w_cnt_nxt = r_cnt + 32'd1;
        end
      end
      WAIT_CLK: begin
        if (w_clk_fall) begin
          w_dat_oe_nxt = ~r_frame[0];
          w_bit_nxt    = 4'd1;
          w_state_nxt  = SHIFT;
        end
      end
      SHIFT: begin
        if (w_clk_fall) begin
          w_dat_oe_nxt = ~r_frame[r_bit];
          if (r_bit == 4'd9) w_state_nxt = ACK;
          else               w_bit_nxt   = r_bit + 4'd1;
        end
      end
      ACK: begin
        if (w_clk_fall) begin
          if (!w_dat_f) begin
            w_state_nxt = WAIT_IDLE;
          end else begin
            w_clk_oe_nxt = 1'b0;
            w_dat_oe_nxt = 1'b0;
            w_err_nxt    = 1'b1;
            w_code_nxt   = ERR_NO_ACK;
            w_state_nxt  = IDLE;
          end
        end
      end
      WAIT_IDLE: begin
        if (w_clk_f && w_dat_f) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
`ifdef PS2_TX_TIMEOUT_EN
    // timeouts override the normal step; a completing done wins the tie
    if (r_state == WAIT_CLK) begin
      if (w_clk_fall) begin
        w_to_nxt = '0;
      end else if (r_to == STO_LAST) begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_err_nxt    = 1'b1;
        w_code_nxt   = ERR_START_TO;
        w_state_nxt  = IDLE;
      end else begin
        w_to_nxt = r_to + 32'd1;
      end
    end else if (r_state inside {SHIFT, ACK, WAIT_IDLE}) begin
      if (r_to == XTO_LAST && !w_done_nxt && !w_err_nxt) begin
        w_clk_oe_nxt = 1'b0;
        w_dat_oe_nxt = 1'b0;
        w_err_nxt    = 1'b1;
        w_code_nxt   = ERR_XFER_TO;
        w_state_nxt  = IDLE;
      end else begin
        w_to_nxt = r_to + 32'd1;
      end
    end
`endif
  end

  assign bus.ready_o    = (r_state == IDLE);
  assign bus.done_o     = r_done;
  assign bus.error_o    = r_err;
  assign bus.err_code_o = r_code;
  assign ps2_clk_oe_o   = r_clk_oe;
  assign ps2_dat_oe_o   = r_dat_oe;
  assign rx_inhibit_o   = (r_state != IDLE);

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx with an open-drain PS/2 device model.
// Covers the PS2_TX_TIMEOUT_EN build when that macro is defined.
module tb_ps2_host_tx;

`ifdef PS2_TX_TIMEOUT_EN
  localparam int STO_US = 100;
`else
  localparam int STO_US = 15000;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  logic clk_oe;
  logic dat_oe;
  logic rx_inh;
  logic dev_clk_low = 1'b0;
  logic dev_dat_low = 1'b0;
  logic ps2_clk;
  logic ps2_dat;

  int total = 0;
  int bad = 0;
  int n_done = 0;
  int n_err = 0;
  int n_both = 0;
  logic [1:0] err_oe = 2'b11;

  always #5 clk = ~clk;

  assign ps2_clk = ~(clk_oe | dev_clk_low);
  assign ps2_dat = ~(dat_oe | dev_dat_low);

  ps2_host_tx_if bus ();

  ps2_host_tx #(
    .START_TIMEOUT_US(STO_US)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_n),
    .bus          (bus),
    .ps2_clk_i    (ps2_clk),
    .ps2_dat_i    (ps2_dat),
    .ps2_clk_oe_o (clk_oe),
    .ps2_dat_oe_o (dat_oe),
    .rx_inhibit_o (rx_inh)
  );

  always @(negedge clk) begin
    if (bus.done_o) n_done++;
    if (bus.error_o) begin
      n_err++;
      err_oe = {clk_oe, dat_oe};
    end
    if (bus.done_o && bus.error_o) n_both++;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic hold(output int n, input bit busy);
    n = 0;
    while (clk_oe === 1'b1 && n < 20000) begin
      n++;
      if (busy && n == 5) begin
        bus.data_i = 8'h55;
        bus.data_valid_i = 1'b1;
      end
      if (busy && n == 105) bus.data_valid_i = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic accept(input logic [7:0] d);
    bus.data_i = d;
    bus.data_valid_i = 1'b1;
    @(negedge clk);
    bus.data_valid_i = 1'b0;
  endtask

  task automatic xfer(input logic [7:0] d, input logic [9:0] fr,
                      input bit ack, input bit glitch, input bit busy);
    int n;
    int lat;
    int d0;
    int e0;
    logic exp;
    d0 = n_done;
    e0 = n_err;
    accept(d);
    chk("accept_ready", bus.ready_o, 0);
    chk("accept_clkoe", clk_oe, 1);
    hold(n, busy);
    chk("clk_hold", n, 6050);
    chk("start_bit", dat_oe, 1);
    repeat (30) @(negedge clk);
    if (glitch) begin
      dev_clk_low = 1'b1;
      repeat (3) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (30) @(negedge clk);
      chk("glitch_nofall", dat_oe, 1);
    end
    for (int i = 0; i < 10; i++) begin
      exp = ~fr[i];
      dev_clk_low = 1'b1;
      if (i == 0 && exp == 1'b0) begin
        lat = 0;
        while (dat_oe !== 1'b0 && lat < 40) begin
          @(negedge clk);
          lat++;
        end
        chk("fall_latency", lat, 11);
        repeat (40 - lat) @(negedge clk);
      end else begin
        repeat (40) @(negedge clk);
      end
      chk($sformatf("bit%0d", i), dat_oe, exp);
      dev_clk_low = 1'b0;
      repeat (40) @(negedge clk);
    end
    dev_dat_low = ack;
    dev_clk_low = 1'b1;
    repeat (40) @(negedge clk);
    dev_clk_low = 1'b0;
    repeat (20) @(negedge clk);
    dev_dat_low = 1'b0;
    repeat (100) @(negedge clk);
    chk("done_count", n_done - d0, ack ? 1 : 0);
    chk("error_count", n_err - e0, ack ? 0 : 1);
    chk("err_code", bus.err_code_o, ack ? 0 : 3);
    chk("ready_after", bus.ready_o, 1);
    chk("rx_inh_after", rx_inh, 0);
    if (!ack) chk("err_oes_zero", err_oe, 0);
  endtask

  initial begin
    int n;
    int e0;
    bus.data_i = 8'h00;
    bus.data_valid_i = 1'b0;
    #2 rst_n = 1'b0;
    repeat (5) @(negedge clk);
    chk("rst_ready", bus.ready_o, 1);
    chk("rst_clk_oe", clk_oe, 0);
    chk("rst_dat_oe", dat_oe, 0);
    chk("rst_rx_inh", rx_inh, 0);
    chk("rst_done", bus.done_o, 0);
    chk("rst_error", bus.error_o, 0);
    chk("rst_code", bus.err_code_o, 0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // 0xED with a 0x55 request arriving while busy
    xfer(8'hED, 10'h3ED, 1'b1, 1'b0, 1'b1);
    repeat (5) @(negedge clk);
    chk("not_queued", rx_inh, 0);
    xfer(8'h55, 10'h355, 1'b1, 1'b0, 1'b0);
    xfer(8'hFF, 10'h3FF, 1'b1, 1'b1, 1'b0);
    xfer(8'h01, 10'h201, 1'b0, 1'b0, 1'b0);

    // device never clocks
    e0 = n_err;
    accept(8'h01);
    hold(n, 1'b0);
`ifdef PS2_TX_TIMEOUT_EN
    repeat (6000) @(negedge clk);
    chk("start_to_err", n_err - e0, 1);
    chk("start_to_code", bus.err_code_o, 1);
    chk("start_to_ready", bus.ready_o, 1);
`else
    repeat (20000) @(negedge clk);
    chk("wait_no_err", n_err - e0, 0);
    chk("wait_busy", rx_inh, 1);
    chk("wait_dat_oe", dat_oe, 1);
    chk("wait_code", bus.err_code_o, 0);
`endif
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // reset in the middle of SHIFT
    accept(8'h80);
    hold(n, 1'b0);
    repeat (30) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      dev_clk_low = 1'b1;
      repeat (40) @(negedge clk);
      dev_clk_low = 1'b0;
      repeat (40) @(negedge clk);
    end
    chk("mid_shift_dat", dat_oe, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_clk_oe", clk_oe, 0);
    chk("async_dat_oe", dat_oe, 0);
    chk("async_rx_inh", rx_inh, 0);
    chk("async_ready", bus.ready_o, 1);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("never_both", n_both, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
